// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory sequencer.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Big-endian lane select and sign/zero extension of a loaded word.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    b = rdata[31:24];
    unique case (offset)
      2'd0: b = rdata[31:24];
      2'd1: b = rdata[23:16];
      2'd2: b = rdata[15:8];
      2'd3: b = rdata[7:0];
      default: b = rdata[31:24];
    endcase
  end

  assign h = offset[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    data = rdata;
    sx   = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        sx   = ~load_unsigned & b[7];
        data = {{24{sx}}, b};
      end
      (size == SZ_HALF): begin
        sx   = ~load_unsigned & h[15];
        data = {{16{sx}}, h};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory sequencer with alignment and load extension.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        is_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        align_err,
  output logic        bus_err
);

  state_e      state, state_d;
  logic        aligned;
  logic        start, take_ack, misalign;
  logic        timeout, expire;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  off_q, size_q;
  logic        uns_q;
  logic [31:0] ext_data;

  always_comb begin
    aligned = 1'b1;
    be_d    = 4'b1111;
    wdata_d = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        aligned = 1'b1;
        be_d    = 4'b1000 >> addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      (size == SZ_HALF): begin
        aligned = ~addr[0];
        be_d    = addr[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        aligned = (addr[1:0] == 2'b00);
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    take_ack = 1'b0;
    misalign = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (op_valid && aligned) begin
          start   = 1'b1;
          state_d = S_WAIT;
        end else if (op_valid) begin
          misalign = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          take_ack = 1'b1;
          state_d  = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must release the pipeline even while an op is still presented.
  assign stall = reset &
    (((state == S_IDLE) & op_valid & aligned) | (state == S_WAIT));

  assign expire = timeout & ~mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      load_data  <= '0;
      load_valid <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      align_err  <= misalign;
      load_valid <= take_ack & ~mem_we;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= is_write;
        mem_be    <= be_d;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdata_d;
        off_q     <= addr[1:0];
        size_q    <= size;
        uns_q     <= load_unsigned;
      end else if (take_ack || expire) begin
        mem_req <= 1'b0;
      end
      if (take_ack && !mem_we) load_data <= ext_data;
      else if (expire)         load_data <= '0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               wait_cnt <= '0;
    else if (start)           wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout = (state == S_WAIT) &&
                   (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err <= 1'b0;
    else        bus_err <= expire;
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  load_align u_align (
    .rdata         (mem_rdata),
    .offset        (off_q),
    .size          (size_q),
    .load_unsigned (uns_q),
    .data          (ext_data)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-level access model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        is_write = 1'b0;
  logic [1:0]  size = '0;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, align_err, bus_err;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .is_write      (is_write),
    .size          (size),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .wdata         (wdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .align_err     (align_err),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input int off);
    logic [3:0] be = '0;
    for (int i = 0; i < nbytes(sz); i++) be[3 - (off + i)] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz,
                                         input logic [31:0] wd);
    logic [31:0] r = '0;
    int nb = nbytes(sz);
    for (int j = 0; j < 4; j++)
      r[8*(3-j) +: 8] = wd[8*((nb-1) - (j % nb)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd,
      input logic [1:0] sz, input logic uns, input int off);
    longint v = 0;
    int nb = nbytes(sz);
    for (int i = 0; i < nb; i++)
      v = v * 256 + longint'((rd >> (8 * (3 - (off + i)))) & 32'hFF);
    if (!uns && v >= (longint'(1) << (8*nb - 1)))
      v = v - (longint'(1) << (8*nb));
    return 32'(v);
  endfunction

  task automatic run_op(input logic w, input logic [1:0] sz, input logic uns,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
      input int d);
    int nb, off, stalls;
    logic ok;
    nb = nbytes(sz);
    off = int'(a[1:0]);
    ok = (off % nb) == 0;
    op_valid = 1'b1; is_write = w; size = sz;
    load_unsigned = uns; addr = a; wdata = wd;
    #1;
    chk("stall_c0", 32'(stall), 32'(ok));
    if (!ok) begin
      @(posedge clk); #1;
      chk("align_err", 32'(align_err), 32'd1);
      chk("mis_no_req", 32'(mem_req), 32'd0);
      chk("mis_no_stall", 32'(stall), 32'd0);
      @(negedge clk);
      op_valid = 1'b0;
      @(posedge clk); #1;
      chk("align_clr", 32'(align_err), 32'd0);
      @(negedge clk);
      return;
    end
    stalls = 1;
    @(posedge clk); #1;
    chk("we", 32'(mem_we), 32'(w));
    chk("be", 32'(mem_be), 32'(exp_be(sz, off)));
    chk("maddr", mem_addr, a & 32'hFFFF_FFFC);
    chk("mwdata", mem_wdata, exp_wd(sz, wd));
    for (int k = 1; k <= d; k++) begin
      chk("req_wait", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, a & 32'hFFFF_FFFC);
      if (stall) stalls++;
      @(negedge clk);
      mem_ack = (k == d);
      mem_rdata = (k == d) ? rd : $urandom;
      if ($urandom_range(0, 3) == 0) op_valid = ~op_valid;
      @(posedge clk); #1;
    end
    chk("stall_cnt", 32'(stalls), 32'(d + 1));
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("load_valid", 32'(load_valid), 32'(!w));
    chk("bus_err_0", 32'(bus_err), 32'd0);
    if (!w) chk("load_data", load_data, exp_load(rd, sz, uns, off));
    @(negedge clk);
    op_valid = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    chk("lv_pulse", 32'(load_valid), 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int max_d;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_lv", 32'(load_valid), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_err", 32'(align_err | bus_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    run_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h112233F0, 1);
    run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h112233F0, 3);
    run_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 1);
    run_op(1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 32'h0, 1);
    run_op(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 32'h1234_8001, 1);

`ifdef MEM_TIMEOUT_EN
    max_d = TO;
`else
    max_d = 6;
`endif
    for (int i = 0; i < 60; i++)
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(1, max_d));

    op_valid = 1'b1; is_write = 1'b0; size = 2'd2; addr = 32'h500;
    @(posedge clk); #1;
    chk("rst_mid_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_req0", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_lv", 32'(load_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("late_ack_lv", 32'(load_valid), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_lv2", 32'(load_valid), 32'd0);
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    op_valid = 1'b1; is_write = 1'b0; size = 2'd2; addr = 32'h600;
    @(posedge clk); #1;
    for (int k = 1; k <= TO; k++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      chk("to_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    chk("bus_err", 32'(bus_err), 32'd1);
    chk("to_req0", 32'(mem_req), 32'd0);
    chk("to_stall0", 32'(stall), 32'd0);
    chk("to_lv", 32'(load_valid), 32'd0);
    chk("to_ld", load_data, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk("bus_err_clr", 32'(bus_err), 32'd0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
